wb_port_scheduler: RTL

//  Owns the single write port of the integer regfile and of the FP regfile in WB stage.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_fu_fifo.sv | 43 ++++
 rtl/wb_port_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings and types for the WB-stage write-port scheduler.
package wb_pkg;

  typedef enum logic [1:0] {
    WBSRC_ALU  = 2'b00,
    WBSRC_MEM  = 2'b01,
    WBSRC_PCP4 = 2'b10,
    WBSRC_IM   = 2'b11
  } wbsrc_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DW_HI = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic        fp;
    logic [4:0]  dst;
    logic [31:0] data;
  } fu_entry_t;

endpackage

// File: rtl/wb_fu_fifo.sv
// Two-entry FIFO holding FP-unit results until a regfile write port is free.
import wb_pkg::*;

module wb_fu_fifo (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  fu_entry_t wdata,
  input  logic      pop,
  output fu_entry_t head,
  output logic      empty,
  output logic      full
);

  fu_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  // When full, wr_ptr == rd_ptr: a simultaneous pop reads the old head this
  // cycle while the push overwrites that same slot at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/wb_port_scheduler.sv
// WB-stage owner of the INT and FP regfile write ports: muxes MEM/WB data,
// splits FP double-word writes into two beats and interleaves FP-unit results.
import wb_pkg::*;

module wb_port_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iWrite,
  input  logic        iFloat,
  input  logic        iDW,
  input  logic [1:0]  iWBsrc,
  input  logic [4:0]  iDstReg,
  input  logic [31:0] iALUout1,
  input  logic [31:0] iALUout2,
  input  logic [31:0] iMemOut1,
  input  logic [31:0] iMemOut2,
  input  logic [31:0] iPcp4,
  input  logic [31:0] iIm,
  input  logic        iFuValid,
  input  logic        iFuFloat,
  input  logic [4:0]  iFuDst,
  input  logic [31:0] iFuData,
  output logic        oFuReady,
  output logic        oIntWe,
  output logic [4:0]  oIntAddr,
  output logic [31:0] oIntData,
  output logic        oFpWe,
  output logic [4:0]  oFpAddr,
  output logic [31:0] oFpData,
  output logic        oStall
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_state_e   state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;

  fu_entry_t   head;
  fu_entry_t   fu_in;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic        grant, forced, contended;
  logic        pipe_int, pipe_fp;
  logic [31:0] low_data, hi_data;

  assign fu_in    = '{fp: iFuFloat, dst: iFuDst, data: iFuData};
  assign oFuReady = !rst && (!fifo_full || pop);
  assign push     = iFuValid && oFuReady;

  wb_fu_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fu_in),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    low_data = iALUout1;
    case (wbsrc_e'(iWBsrc))
      WBSRC_ALU:  low_data = iALUout1;
      WBSRC_MEM:  low_data = iMemOut1;
      WBSRC_PCP4: low_data = iPcp4;
      WBSRC_IM:   low_data = iIm;
      default:    low_data = iALUout1;
    endcase
    hi_data = (wbsrc_e'(iWBsrc) == WBSRC_MEM) ? iMemOut2 : iALUout2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    oIntWe    = 1'b0;
    oIntAddr  = '0;
    oIntData  = '0;
    oFpWe     = 1'b0;
    oFpAddr   = '0;
    oFpData   = '0;
    oStall    = 1'b0;
    grant     = 1'b0;
    forced    = 1'b0;
    contended = 1'b0;
    pipe_int  = iWrite && !iFloat;
    pipe_fp   = iWrite && iFloat;

    if (!rst) begin
      if (state_q == DW_HI) begin
        oFpWe   = 1'b1;
        oFpAddr = iDstReg + 5'd1;
        oFpData = hi_data;
        state_d = IDLE;
        grant   = !fifo_empty && !head.fp;
      end else begin
        contended = !fifo_empty && (head.fp ? pipe_fp : pipe_int);
        if (!fifo_empty && !contended) begin
          grant = 1'b1;
        end else if (contended && starve_q == CW'(STARVE_LIMIT)) begin
          grant  = 1'b1;
          forced = 1'b1;
          oStall = 1'b1;
        end
        // A forced grant swallows the pipeline write; the stall replays it.
        if (!forced) begin
          if (pipe_fp) begin
            oFpWe   = 1'b1;
            oFpAddr = iDstReg;
            oFpData = low_data;
            if (iDW) begin
              oStall  = 1'b1;
              state_d = DW_HI;
            end
          end else if (pipe_int && iDstReg != 5'd0) begin
            oIntWe   = 1'b1;
            oIntAddr = iDstReg;
            oIntData = low_data;
          end
        end
      end

      if (grant) begin
        if (head.fp) begin
          oFpWe   = 1'b1;
          oFpAddr = head.dst;
          oFpData = head.data;
        end else if (head.dst != 5'd0) begin
          oIntWe   = 1'b1;
          oIntAddr = head.dst;
          oIntData = head.data;
        end
      end
    end

    pop = grant;

    starve_d = starve_q;
    if (fifo_empty || grant)
      starve_d = '0;
    else if (starve_q != CW'(STARVE_LIMIT))
      starve_d = starve_q + CW'(1);
  end

endmodule
